// File: rtl/axis_reg_stage.sv
// AXI4-Stream register slice: bypass wire, one-entry buffer or full-rate skid buffer.
// In the registered modes s_axis_tready comes straight from a flop.
module axis_reg_stage #(
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8) ? 1 : 0,
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int LAST_ENABLE = 1,
    parameter int ID_ENABLE   = 0,
    parameter int ID_WIDTH    = 8,
    parameter int DEST_ENABLE = 0,
    parameter int DEST_WIDTH  = 8,
    parameter int USER_ENABLE = 1,
    parameter int USER_WIDTH  = 1,
    parameter int REG_TYPE    = 2
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [ID_WIDTH-1:0]   s_axis_tid,
    input  logic [DEST_WIDTH-1:0] s_axis_tdest,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [ID_WIDTH-1:0]   m_axis_tid,
    output logic [DEST_WIDTH-1:0] m_axis_tdest,
    output logic [USER_WIDTH-1:0] m_axis_tuser
);

    localparam int USER_LSB      = 0;
    localparam int DEST_LSB      = USER_LSB + USER_WIDTH;
    localparam int ID_LSB        = DEST_LSB + DEST_WIDTH;
    localparam int LAST_LSB      = ID_LSB + ID_WIDTH;
    localparam int KEEP_LSB      = LAST_LSB + 1;
    localparam int DATA_LSB      = KEEP_LSB + KEEP_WIDTH;
    localparam int PAYLOAD_WIDTH = DATA_LSB + DATA_WIDTH;

    logic [PAYLOAD_WIDTH-1:0] s_payload;
    logic [PAYLOAD_WIDTH-1:0] m_payload;

    logic [PAYLOAD_WIDTH-1:0] m_data_q;
    logic [PAYLOAD_WIDTH-1:0] m_data_d;
    logic [PAYLOAD_WIDTH-1:0] temp_data_q;
    logic [PAYLOAD_WIDTH-1:0] temp_data_d;
    logic                     m_valid_q;
    logic                     m_valid_d;
    logic                     temp_valid_q;
    logic                     temp_valid_d;
    logic                     s_ready_q;
    logic                     s_ready_d;

    assign s_payload = {s_axis_tdata, s_axis_tkeep, s_axis_tlast,
                        s_axis_tid, s_axis_tdest, s_axis_tuser};

    // The skid path relies on s_ready_q implying an empty temp register,
    // so an accepted beat never has to compete with a pending temp beat.
    always_comb begin
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        temp_valid_d = temp_valid_q;
        temp_data_d  = temp_data_q;
        s_ready_d    = 1'b0;

        if (REG_TYPE == 2) begin
            s_ready_d = m_axis_tready ||
                        (!temp_valid_q && (!m_valid_q || !s_axis_tvalid));
            if (m_axis_tready || !m_valid_q) begin
                if (temp_valid_q) begin
                    m_valid_d    = 1'b1;
                    m_data_d     = temp_data_q;
                    temp_valid_d = 1'b0;
                end else begin
                    m_valid_d = s_ready_q && s_axis_tvalid;
                    m_data_d  = s_payload;
                end
            end else if (s_ready_q && s_axis_tvalid) begin
                temp_valid_d = 1'b1;
                temp_data_d  = s_payload;
            end
        end else if (REG_TYPE == 1) begin
            if (s_ready_q) begin
                m_valid_d = s_axis_tvalid;
                m_data_d  = s_payload;
            end else if (m_axis_tready) begin
                m_valid_d = 1'b0;
            end
            s_ready_d = !m_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q    <= 1'b0;
            temp_valid_q <= 1'b0;
            s_ready_q    <= 1'b0;
        end else begin
            m_valid_q    <= m_valid_d;
            temp_valid_q <= temp_valid_d;
            s_ready_q    <= s_ready_d;
        end
    end

    // Payload flops carry no reset; the valid flags alone qualify them.
    always_ff @(posedge clk) begin
        m_data_q    <= m_data_d;
        temp_data_q <= temp_data_d;
    end

    always_comb begin
        if (REG_TYPE == 0) begin
            m_payload     = s_payload;
            m_axis_tvalid = s_axis_tvalid;
            s_axis_tready = m_axis_tready;
        end else begin
            m_payload     = m_data_q;
            m_axis_tvalid = m_valid_q;
            s_axis_tready = s_ready_q;
        end
    end

    // Disabled sidebands are tied off here so they stay constant even
    // before the unreset payload flops have been loaded.
    assign m_axis_tdata = m_payload[DATA_LSB +: DATA_WIDTH];
    assign m_axis_tkeep = (KEEP_ENABLE != 0) ? m_payload[KEEP_LSB +: KEEP_WIDTH]
                                             : {KEEP_WIDTH{1'b1}};
    assign m_axis_tlast = (LAST_ENABLE != 0) ? m_payload[LAST_LSB] : 1'b1;
    assign m_axis_tid   = (ID_ENABLE != 0)   ? m_payload[ID_LSB +: ID_WIDTH]
                                             : {ID_WIDTH{1'b0}};
    assign m_axis_tdest = (DEST_ENABLE != 0) ? m_payload[DEST_LSB +: DEST_WIDTH]
                                             : {DEST_WIDTH{1'b0}};
    assign m_axis_tuser = (USER_ENABLE != 0) ? m_payload[USER_LSB +: USER_WIDTH]
                                             : {USER_WIDTH{1'b0}};

endmodule

// File: tb/tb_axis_reg_stage.sv
// Bench for axis_reg_stage: skid, simple-buffer and bypass instances side by side,
// with per-instance scoreboards fed from input handshakes.
`timescale 1ns/1ps
module tb_axis_reg_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Skid instance (k_), simple-buffer instance (b_), bypass instance (w_)
    logic [7:0] k_s_data, k_m_data, b_s_data, b_m_data, w_s_data, w_m_data;
    logic [0:0] k_s_keep, k_m_keep, b_s_keep, b_m_keep, w_s_keep, w_m_keep;
    logic       k_s_valid, k_s_ready, k_m_valid, k_m_ready;
    logic       b_s_valid, b_s_ready, b_m_valid, b_m_ready;
    logic       w_s_valid, w_s_ready, w_m_valid, w_m_ready;
    logic       k_s_last, k_m_last, b_s_last, b_m_last, w_s_last, w_m_last;
    logic [7:0] k_s_id, k_m_id, b_s_id, b_m_id, w_s_id, w_m_id;
    logic [7:0] k_s_dest, k_m_dest, b_s_dest, b_m_dest, w_s_dest, w_m_dest;
    logic [0:0] k_s_user, k_m_user, b_s_user, b_m_user, w_s_user, w_m_user;

    axis_reg_stage #(.REG_TYPE(2)) dut_skid (
        .clk(clk), .rst(rst),
        .s_axis_tdata(k_s_data), .s_axis_tkeep(k_s_keep), .s_axis_tvalid(k_s_valid),
        .s_axis_tready(k_s_ready), .s_axis_tlast(k_s_last), .s_axis_tid(k_s_id),
        .s_axis_tdest(k_s_dest), .s_axis_tuser(k_s_user),
        .m_axis_tdata(k_m_data), .m_axis_tkeep(k_m_keep), .m_axis_tvalid(k_m_valid),
        .m_axis_tready(k_m_ready), .m_axis_tlast(k_m_last), .m_axis_tid(k_m_id),
        .m_axis_tdest(k_m_dest), .m_axis_tuser(k_m_user)
    );

    axis_reg_stage #(.REG_TYPE(1), .ID_ENABLE(1)) dut_simple (
        .clk(clk), .rst(rst),
        .s_axis_tdata(b_s_data), .s_axis_tkeep(b_s_keep), .s_axis_tvalid(b_s_valid),
        .s_axis_tready(b_s_ready), .s_axis_tlast(b_s_last), .s_axis_tid(b_s_id),
        .s_axis_tdest(b_s_dest), .s_axis_tuser(b_s_user),
        .m_axis_tdata(b_m_data), .m_axis_tkeep(b_m_keep), .m_axis_tvalid(b_m_valid),
        .m_axis_tready(b_m_ready), .m_axis_tlast(b_m_last), .m_axis_tid(b_m_id),
        .m_axis_tdest(b_m_dest), .m_axis_tuser(b_m_user)
    );

    axis_reg_stage #(.REG_TYPE(0), .LAST_ENABLE(0), .USER_ENABLE(0)) dut_bypass (
        .clk(clk), .rst(rst),
        .s_axis_tdata(w_s_data), .s_axis_tkeep(w_s_keep), .s_axis_tvalid(w_s_valid),
        .s_axis_tready(w_s_ready), .s_axis_tlast(w_s_last), .s_axis_tid(w_s_id),
        .s_axis_tdest(w_s_dest), .s_axis_tuser(w_s_user),
        .m_axis_tdata(w_m_data), .m_axis_tkeep(w_m_keep), .m_axis_tvalid(w_m_valid),
        .m_axis_tready(w_m_ready), .m_axis_tlast(w_m_last), .m_axis_tid(w_m_id),
        .m_axis_tdest(w_m_dest), .m_axis_tuser(w_m_user)
    );

    logic [26:0] k_m_pl, b_m_pl;
    assign k_m_pl = {k_m_data, k_m_keep, k_m_last, k_m_id, k_m_dest, k_m_user};
    assign b_m_pl = {b_m_data, b_m_keep, b_m_last, b_m_id, b_m_dest, b_m_user};

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [26:0] k_q[$];
    int          k_qc[$];
    bit          k_chk_lat = 1'b0;
    bit          k_prev_hold = 1'b0;
    logic [26:0] k_prev_pl;
    int          k_lat;

    // Skid scoreboard: the expected beat has keep forced high and id/dest
    // zeroed, since those sidebands are disabled on this instance.
    always @(negedge clk) begin
        if (rst) begin
            k_q.delete();
            k_qc.delete();
            k_prev_hold = 1'b0;
        end else begin
            if (k_prev_hold) begin
                checkOutput("k_hold_valid", 32'(k_m_valid), 32'd1);
                checkOutput("k_hold_payload", 32'(k_m_pl), 32'(k_prev_pl));
            end
            k_prev_hold = k_m_valid && !k_m_ready;
            k_prev_pl   = k_m_pl;
            if (k_s_valid && k_s_ready) begin
                k_q.push_back({k_s_data, 1'b1, k_s_last, 16'h0000, k_s_user});
                k_qc.push_back(cyc);
            end
            if (k_m_valid && k_m_ready) begin
                checkOutput("k_q_nonempty", 32'(k_q.size() != 0), 32'd1);
                if (k_q.size() != 0) begin
                    checkOutput("k_beat", 32'(k_m_pl), 32'(k_q.pop_front()));
                    k_lat = cyc - k_qc.pop_front();
                    if (k_chk_lat) checkOutput("k_latency", k_lat, 32'd1);
                end
            end
        end
    end

    logic [26:0] b_q[$];
    bit          b_chk_gap = 1'b0;
    bit          b_have_prev = 1'b0;
    int          b_prev_out = 0;

    always @(negedge clk) begin
        if (rst) begin
            b_q.delete();
        end else begin
            if (b_s_valid && b_s_ready)
                b_q.push_back({b_s_data, 1'b1, b_s_last, b_s_id, 8'h00, b_s_user});
            if (b_m_valid && b_m_ready) begin
                checkOutput("b_q_nonempty", 32'(b_q.size() != 0), 32'd1);
                if (b_q.size() != 0) checkOutput("b_beat", 32'(b_m_pl), 32'(b_q.pop_front()));
                if (b_chk_gap && b_have_prev) checkOutput("b_gap", cyc - b_prev_out, 32'd2);
                b_have_prev = 1'b1;
                b_prev_out  = cyc;
            end
        end
    end

    task automatic driveSkid(input int i);
        k_s_valid = (i < 8);
        k_s_data  = 8'(i);
        k_s_last  = (i == 7);
        k_s_user  = 1'(i % 2);
        k_s_id    = 8'h5A;
        k_s_dest  = 8'hA5;
        k_s_keep  = 1'b0;
    endtask

    task automatic driveSimple(input int i);
        b_s_valid = (i < 8);
        b_s_data  = 8'(8'h30 + i);
        b_s_last  = (i == 7);
        b_s_user  = 1'(i % 2);
        b_s_id    = 8'(8'h10 + i);
        b_s_dest  = 8'h33;
        b_s_keep  = 1'b0;
    endtask

    task automatic applyStimulus();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("k_rst_valid", 32'(k_m_valid), 32'd0);
        checkOutput("k_rst_ready", 32'(k_s_ready), 32'd0);
        checkOutput("b_rst_valid", 32'(b_m_valid), 32'd0);
        checkOutput("b_rst_ready", 32'(b_s_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("k_ready_after_rst", 32'(k_s_ready), 32'd1);
        checkOutput("b_ready_after_rst", 32'(b_s_ready), 32'd1);
    endtask

    task automatic runSkid(input bit doStall);
        int idx = 0, n = 0, nout = 0, first = 0, last = 0;
        int lowLeft = 0, accLow = 0;
        bit stalled = 1'b0;
        k_chk_lat = !doStall;
        @(posedge clk); #1;
        k_m_ready = 1'b1;
        driveSkid(idx);
        while (nout < 8 && n < 100) begin
            @(negedge clk);
            n++;
            if (k_s_valid && k_s_ready) begin
                idx++;
                if (!k_m_ready) accLow++;
            end
            if (k_m_valid && k_m_ready) begin
                if (nout == 0) first = n;
                last = n;
                nout++;
            end
            if (!k_m_ready && lowLeft == 1) checkOutput("k_stall_ready_low", 32'(k_s_ready), 32'd0);
            @(posedge clk); #1;
            if (lowLeft > 0) begin
                lowLeft--;
                if (lowLeft == 0) begin
                    k_m_ready = 1'b1;
                    checkOutput("k_stall_accepts_le2", 32'(accLow <= 2), 32'd1);
                end
            end else if (doStall && !stalled && nout >= 2) begin
                stalled   = 1'b1;
                k_m_ready = 1'b0;
                lowLeft   = 5;
            end
            driveSkid(idx);
        end
        checkOutput("k_no_timeout", 32'(n < 100), 32'd1);
        checkOutput("k_out_count", nout, 32'd8);
        if (!doStall) checkOutput("k_consecutive", last - first, 32'd7);
        if (doStall) checkOutput("k_stall_done", 32'(stalled), 32'd1);
        k_chk_lat = 1'b0;
    endtask

    task automatic runSimple();
        int idx = 0, n = 0, nout = 0;
        b_chk_gap = 1'b1;
        @(posedge clk); #1;
        b_m_ready = 1'b1;
        driveSimple(idx);
        while (nout < 8 && n < 60) begin
            @(negedge clk);
            if (n < 8) checkOutput("b_ready_toggle", 32'(b_s_ready), 32'(n % 2 == 0));
            n++;
            if (b_s_valid && b_s_ready) idx++;
            if (b_m_valid && b_m_ready) nout++;
            @(posedge clk); #1;
            driveSimple(idx);
        end
        checkOutput("b_no_timeout", 32'(n < 60), 32'd1);
        checkOutput("b_out_count", nout, 32'd8);
        b_chk_gap = 1'b0;
    endtask

    task automatic runBypass();
        logic [7:0] d;
        logic       v, r;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            d = 8'($urandom);
            v = 1'(i / 2 % 2);
            r = 1'(i % 2);
            w_s_data  = d;
            w_s_valid = v;
            w_m_ready = r;
            w_s_id    = 8'h5A;
            w_s_last  = 1'b0;
            w_s_user  = 1'b1;
            #1;
            checkOutput("w_data", 32'(w_m_data), 32'(d));
            checkOutput("w_valid", 32'(w_m_valid), 32'(v));
            checkOutput("w_ready", 32'(w_s_ready), 32'(r));
            checkOutput("w_last_const", 32'(w_m_last), 32'd1);
            checkOutput("w_tid_zero", 32'(w_m_id), 32'd0);
            checkOutput("w_user_zero", 32'(w_m_user), 32'd0);
        end
    endtask

    task automatic runResetMidFrame();
        int acc = 0, seen = 0;
        @(posedge clk); #1;
        k_m_ready = 1'b0;
        driveSkid(0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (k_s_valid && k_s_ready) acc++;
            @(posedge clk); #1;
            if (acc < 2) driveSkid(acc);
            else k_s_valid = 1'b0;
        end
        k_s_valid = 1'b0;
        checkOutput("k_buffered_before_rst", acc, 32'd2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("k_rst_mid_valid", 32'(k_m_valid), 32'd0);
        @(negedge clk);
        checkOutput("k_rst_mid_ready", 32'(k_s_ready), 32'd1);
        @(posedge clk); #1;
        k_m_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (k_m_valid) seen++;
        end
        checkOutput("k_no_stale_beat", seen, 32'd0);
    endtask

    initial begin
        k_m_ready = 1'b0; b_m_ready = 1'b0; w_m_ready = 1'b0;
        driveSkid(8);
        driveSimple(8);
        w_s_data = 8'h00; w_s_keep = 1'b0; w_s_valid = 1'b0; w_s_last = 1'b0;
        w_s_id = 8'h00; w_s_dest = 8'h00; w_s_user = 1'b0;

        applyStimulus();
        runSkid(1'b0);
        runSkid(1'b1);
        runSimple();
        runBypass();
        runResetMidFrame();
        repeat (3) @(posedge clk);
        checkOutput("k_q_drained", k_q.size(), 32'd0);
        checkOutput("b_q_drained", b_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
